// File: rtl/bit_rev_pkg.sv
// bit_rev_pkg: shared FSM states, default sizes and the address bit-reversal helper
package bit_rev_pkg;

    localparam int N_LOG2_DEF = 5;
    localparam int DATA_W_DEF = 16;
    localparam int MAX_W      = 32;

    typedef enum logic [2:0] {IDLE, COPY, VERIFY, DONE, ERROR} state_t;

    // Reverses the low w bits of a; bits at and above w come back as zero.
    function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] a, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++)
            if (i < w) r[i] = a[w-1-i];
        return r;
    endfunction

endpackage

// File: rtl/bitrev_ram.sv
// bitrev_ram: N x DATA_W destination buffer, sync write, async read (read port only with BITREV_SELFCHECK_EN)
module bitrev_ram #(
    parameter int AW = 5,
    parameter int DW = 16
) (
    input  logic          Clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
`ifdef BITREV_SELFCHECK_EN
    ,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
`endif
);

    logic [DW-1:0] mem [2**AW];

    // Contents are deliberately not reset so a pass survives a reset.
    always_ff @(posedge Clk)
        if (we) mem[wr_addr] <= wr_data;

`ifdef BITREV_SELFCHECK_EN
    assign rd_data = mem[rd_addr];
`endif

endmodule

// File: rtl/bit_rev_order_test.sv
// bit_rev_order_test: copies an index ROM into a RAM in bit-reversed order, raises tc when done (BITREV_SELFCHECK_EN adds a verify pass)
module bit_rev_order_test
    import bit_rev_pkg::*;
#(
    parameter int N_LOG2 = N_LOG2_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic Clk,
    input  logic reset,
    input  logic start,
    output logic tc
);

    state_t              state;
    logic [N_LOG2-1:0]   cnt;
    logic [N_LOG2-1:0]   addr;
    logic [DATA_W-1:0]   src_q;
`ifdef BITREV_SELFCHECK_EN
    logic [DATA_W-1:0]   rd_data;
`endif

    assign addr  = N_LOG2'(bitrev(MAX_W'(cnt), N_LOG2));
    assign src_q = DATA_W'(cnt);

    bitrev_ram #(.AW(N_LOG2), .DW(DATA_W)) u_ram (
        .Clk     (Clk),
        .we      (state == COPY),
        .wr_addr (addr),
        .wr_data (src_q)
`ifdef BITREV_SELFCHECK_EN
        ,
        .rd_addr (addr),
        .rd_data (rd_data)
`endif
    );

    // Sequencer: cnt walks 0..N-1 in COPY (and VERIFY), wrapping to 0 on each state change; tc is set on entry to DONE.
    always_ff @(posedge Clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            tc    <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (start) begin
                        state <= COPY;
                        cnt   <= '0;
                    end
                COPY: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
`ifdef BITREV_SELFCHECK_EN
                        state <= VERIFY;
`else
                        state <= DONE;
                        tc    <= 1'b1;
`endif
                    end
                end
`ifdef BITREV_SELFCHECK_EN
                VERIFY:
                    if (rd_data != src_q) begin
                        state <= ERROR;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (&cnt) begin
                            state <= DONE;
                            tc    <= 1'b1;
                        end
                    end
                ERROR: ;
`endif
                DONE:
                    if (start) begin
                        state <= COPY;
                        cnt   <= '0;
                        tc    <= 1'b0;
                    end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    tc    <= 1'b0;
                end
            endcase
        end

endmodule

// File: tb/tb_bit_rev_order_test.sv
// tb_bit_rev_order_test: directed bench for bit_rev_order_test; honours BITREV_SELFCHECK_EN for latency and the error path
module tb_bit_rev_order_test;
    import bit_rev_pkg::*;

`ifdef BITREV_SELFCHECK_EN
    localparam int LAT = 64;
`else
    localparam int LAT = 32;
`endif
    localparam int WIN = 3 * LAT + 4;

    logic Clk = 1'b1;
    logic reset;
    logic start;
    logic tc;

    int total  = 0;
    int passed = 0;
    int rise, hi, r1, r2, r3, nr;
    logic first;

    bit_rev_order_test dut (
        .Clk   (Clk),
        .reset (reset),
        .start (start),
        .tc    (tc)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Called on a falling edge; start is captured at the next rising edge (E0), sample j follows edge E0+j.
    task automatic run_pass(input int hold, output int r, output int h, output logic f);
        r = -1;
        h = 0;
        f = 1'bx;
        start = 1'b1;
        for (int j = 0; j < LAT + 8; j++) begin
            @(negedge Clk);
            if (j == hold - 1) start = 1'b0;
            if (j == 0) f = tc;
            if (tc === 1'b1) begin
                h++;
                if (r < 0) r = j;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        @(negedge Clk);
        chk("tc_in_reset", 32'(tc), 0);
        repeat (10) @(negedge Clk);
        reset = 1'b0;
        chk("tc_after_release", 32'(tc), 0);
        chk("state_after_release", 32'(dut.state), 32'(IDLE));
        repeat (2) @(negedge Clk);

        // 4-cycle start pulse from IDLE
        run_pass(4, rise, hi, first);
        chk("first_tc_after_capture", 32'(first), 0);
        chk("first_rise_edge", 32'(rise), LAT);
        chk("first_single_pass_hold", 32'(hi), 8);

        // backdoor check of the bit-reversed destination
        chk("dst16", 32'(dut.u_ram.mem[16]), 1);
        chk("dst24", 32'(dut.u_ram.mem[24]), 3);
        chk("dst12", 32'(dut.u_ram.mem[12]), 6);
        chk("dst0",  32'(dut.u_ram.mem[0]),  0);
        chk("dst31", 32'(dut.u_ram.mem[31]), 31);

        // restart from DONE
        run_pass(1, rise, hi, first);
        chk("restart_tc_drop", 32'(first), 0);
        chk("restart_rise_edge", 32'(rise), LAT);
        chk("restart_hold", 32'(hi), 8);
        chk("restart_dst16", 32'(dut.u_ram.mem[16]), 1);
        chk("restart_dst1", 32'(dut.u_ram.mem[1]), 16);

        // reset in the middle of COPY
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (9) @(negedge Clk);
        chk("midcopy_state", 32'(dut.state), 32'(COPY));
        reset = 1'b1;
        #1;
        chk("abort_tc", 32'(tc), 0);
        chk("abort_state", 32'(dut.state), 32'(IDLE));
        chk("abort_cnt", 32'(dut.cnt), 0);
        @(negedge Clk);
        reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk("idle_wait_no_start", 32'(dut.state), 32'(IDLE));
        run_pass(1, rise, hi, first);
        chk("post_abort_rise_edge", 32'(rise), LAT);
        chk("post_abort_hold", 32'(hi), 8);

        // start held high: back-to-back passes with one DONE cycle each
        r1 = -1; r2 = -1; r3 = -1; nr = 0;
        start = 1'b1;
        for (int j = 0; j < WIN; j++) begin
            @(negedge Clk);
            if (tc === 1'b1) begin
                nr++;
                if (nr == 1) r1 = j;
                if (nr == 2) r2 = j;
                if (nr == 3) r3 = j;
            end
        end
        start = 1'b0;
        chk("held_tc_high_count", 32'(nr), 3);
        chk("held_first_rise", 32'(r1), LAT);
        chk("held_period_1", 32'(r2 - r1), LAT + 1);
        chk("held_period_2", 32'(r3 - r2), LAT + 1);
        rise = -1;
        for (int j = 0; j < LAT + 4; j++) begin
            @(negedge Clk);
            if (tc === 1'b1 && rise < 0) rise = j;
        end
        chk("held_last_rise", 32'(rise), LAT - 1);
        hi = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge Clk);
            if (tc === 1'b1) hi++;
        end
        chk("held_release_stays_done", 32'(hi), 10);

`ifdef BITREV_SELFCHECK_EN
        // corrupt dst[16] once COPY has finished; VERIFY must trap in ERROR
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        nr = 0;
        while (dut.state !== VERIFY && nr < 100) begin
            @(negedge Clk);
            nr++;
        end
        chk("reach_verify", 32'(dut.state), 32'(VERIFY));
        dut.u_ram.mem[16] = '0;
        hi = 0;
        for (int j = 0; j < 200; j++) begin
            @(negedge Clk);
            start = (j % 7 == 3);
            if (tc !== 1'b0) hi++;
        end
        start = 1'b0;
        chk("error_tc_never_high", 32'(hi), 0);
        chk("error_state", 32'(dut.state), 32'(ERROR));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
